// File: rtl/fwd_result_pipe_if.sv
// fwd_result_pipe_if: issue, FU result, operand read and write-back bus of the execute-stage result pipeline.
// The master side is the issue / operand-fetch logic; the slave side is fwd_result_pipe.
interface fwd_result_pipe_if #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 7,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int NRD    = 6,
  parameter int LAT_W  = $clog2(DEPTH + 1)
);
  logic [LANES-1:0]        iss_valid;
  logic [LANES-1:0]        iss_wr;
  logic [LANES*ADDR_W-1:0] iss_addr;
  logic [LANES*LAT_W-1:0]  iss_lat;
  logic                    iss_stall;
  logic [LANES*DATA_W-1:0] res_data;
  logic [NRD*ADDR_W-1:0]   rd_addr;
  logic [NRD*DATA_W-1:0]   rf_data;
  logic [NRD*DATA_W-1:0]   rd_data;
  logic [NRD-1:0]          rd_hit;
  logic [LANES-1:0]        wb_en;
  logic [LANES*ADDR_W-1:0] wb_addr;
  logic [LANES*DATA_W-1:0] wb_data;
  logic                    lat_err;

  modport master (
    output iss_valid, iss_wr, iss_addr, iss_lat, res_data, rd_addr, rf_data,
    input  iss_stall, rd_data, rd_hit, wb_en, wb_addr, wb_data, lat_err
  );

  modport slave (
    input  iss_valid, iss_wr, iss_addr, iss_lat, res_data, rd_addr, rf_data,
    output iss_stall, rd_data, rd_hit, wb_en, wb_addr, wb_data, lat_err
  );
endinterface

// File: rtl/fwd_result_pipe.sv
// fwd_result_pipe: in-flight result pipeline with youngest-match forwarding, RAW / write-back-slot stall and RF write ports.
// Define FWD_BYPASS_EN to forward a result in the same cycle its FU presents it on res_data.
module fwd_result_pipe #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 7,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int NRD    = 6,
  parameter int LAT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  fwd_result_pipe_if.slave bus
);

`ifdef FWD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LAT_W-1:0]  lat;
    logic              rdy;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t                  pipe [1:DEPTH][LANES];
  entry_t                  issue_e [LANES];
  logic [LANES-1:0]        lat_bad;
  logic                    conflict;
  logic                    raw_hazard;
  logic                    stall;
  logic                    lat_err_q;
  logic [NRD-1:0]          rd_hit_v;
  logic [NRD*DATA_W-1:0]   rd_data_v;
  logic [LANES-1:0]        wb_en_v;
  logic [LANES*ADDR_W-1:0] wb_addr_v;
  logic [LANES*DATA_W-1:0] wb_data_v;

  // Illegal latencies are folded to DEPTH-1 before they reach the conflict check or the pipe.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lat_bad[l]       = (bus.iss_lat[l*LAT_W +: LAT_W] == '0) ||
                         (bus.iss_lat[l*LAT_W +: LAT_W] >= LAT_W'(DEPTH));
      issue_e[l]       = '0;
      issue_e[l].valid = 1'b1;
      issue_e[l].wr    = bus.iss_wr[l];
      issue_e[l].addr  = bus.iss_addr[l*ADDR_W +: ADDR_W];
      issue_e[l].lat   = lat_bad[l] ? LAT_W'(DEPTH - 1) : bus.iss_lat[l*LAT_W +: LAT_W];
    end
  end

  // A new issue may not reach its capture stage in the same cycle as an older entry on its lane.
  always_comb begin
    conflict = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 1; s <= DEPTH; s++) begin
        if (bus.iss_valid[l] && pipe[s][l].valid && int'(pipe[s][l].lat) > s &&
            int'(issue_e[l].lat) == int'(pipe[s][l].lat) - s)
          conflict = 1'b1;
      end
    end
  end

  always_comb begin : lookup
    logic              found;
    logic              ready;
    logic [DATA_W-1:0] win;
    // NOTE: every variable gets a value before the search loops read or conditionally update it, so no latch is inferred.
    rd_hit_v   = '0;
    rd_data_v  = '0;
    raw_hazard = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      found = 1'b0;
      ready = 1'b0;
      win   = '0;
      // Scan oldest to youngest so the last match left standing is the youngest producer.
      for (int s = DEPTH; s >= 1; s--) begin
        for (int l = 0; l < LANES; l++) begin
          if (pipe[s][l].valid && pipe[s][l].wr &&
              pipe[s][l].addr == bus.rd_addr[p*ADDR_W +: ADDR_W]) begin
            found = 1'b1;
            if (BYPASS && !pipe[s][l].rdy && pipe[s][l].lat == LAT_W'(s)) begin
              ready = 1'b1;
              win   = bus.res_data[l*DATA_W +: DATA_W];
            end else begin
              ready = pipe[s][l].rdy;
              win   = pipe[s][l].data;
            end
          end
        end
      end
      rd_hit_v[p]                   = found & ready;
      rd_data_v[p*DATA_W +: DATA_W] = (found & ready) ? win : bus.rf_data[p*DATA_W +: DATA_W];
      raw_hazard                    = raw_hazard | (found & ~ready);
    end
  end

  assign stall = conflict | raw_hazard;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      wb_en_v[l]                    = pipe[DEPTH][l].valid & pipe[DEPTH][l].wr;
      wb_addr_v[l*ADDR_W +: ADDR_W] = pipe[DEPTH][l].addr;
      wb_data_v[l*DATA_W +: DATA_W] = pipe[DEPTH][l].data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payload fields are reset along with the valid bits because wb_addr / wb_data must read zero out of reset.
      for (int s = 1; s <= DEPTH; s++)
        for (int l = 0; l < LANES; l++)
          pipe[s][l] <= '0;
      lat_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let every stage read its predecessor's pre-edge value, so the shift order is irrelevant.
      for (int l = 0; l < LANES; l++) begin
        pipe[1][l] <= (!stall && bus.iss_valid[l]) ? issue_e[l] : '0;
        for (int s = 2; s <= DEPTH; s++) begin
          pipe[s][l] <= pipe[s-1][l];
          if (pipe[s-1][l].valid && pipe[s-1][l].lat == LAT_W'(s - 1)) begin
            pipe[s][l].rdy  <= 1'b1;
            pipe[s][l].data <= bus.res_data[l*DATA_W +: DATA_W];
          end
        end
      end
      lat_err_q <= !stall && |(bus.iss_valid & lat_bad);
    end
  end

  assign bus.iss_stall = stall;
  assign bus.rd_hit    = rd_hit_v;
  assign bus.rd_data   = rd_data_v;
  assign bus.wb_en     = wb_en_v;
  assign bus.wb_addr   = wb_addr_v;
  assign bus.wb_data   = wb_data_v;
  assign bus.lat_err   = lat_err_q;

endmodule

// File: tb/tb_fwd_result_pipe.sv
// tb_fwd_result_pipe: randomized and directed stimulus against an issue-cycle-based reference model;
// write-backs are checked by a separate monitor popping per-lane expectation queues.
module tb_fwd_result_pipe;
  localparam int LANES  = 2;
  localparam int DEPTH  = 7;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;
  localparam int NRD    = 6;
  localparam int LAT_W  = $clog2(DEPTH + 1);

  typedef struct {
    int                ti;
    int                lane;
    bit                wr;
    int                addr;
    int                lat;
    logic [DATA_W-1:0] data;
  } item_t;

  typedef struct {
    int                cyc;
    int                addr;
    logic [DATA_W-1:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_result_pipe_if #(.LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                       .NRD(NRD), .LAT_W(LAT_W)) bus ();

  fwd_result_pipe #(.LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                    .NRD(NRD), .LAT_W(LAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  item_t inflight [$];
  wb_t   wbq [LANES][$];
  bit    exp_lat_err     = 1'b0;
  bit    exp_lat_err_nxt = 1'b0;

  bit [LANES-1:0]    iv;
  bit [LANES-1:0]    iw;
  int                ia [LANES];
  int                il [LANES];
  logic [DATA_W-1:0] id [LANES];
  int                ra [NRD];
  logic [DATA_W-1:0] rf [NRD];

  task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int eff_lat(int x);
    return (x == 0 || x >= DEPTH) ? DEPTH - 1 : x;
  endfunction

  // Drive one cycle's inputs, predict the combinational outputs from the in-flight list, check, then record accepted issues.
  task automatic eval();
    logic [DATA_W-1:0] res [LANES];
    logic [DATA_W-1:0] m_data [NRD];
    bit [NRD-1:0]      m_hit;
    bit                hazard   = 1'b0;
    bit                conflict = 1'b0;
    bit                m_stall;
    item_t             it;
    wb_t               w;

    for (int i = inflight.size() - 1; i >= 0; i--)
      if (cyc - inflight[i].ti > DEPTH) inflight.delete(i);

    for (int ln = 0; ln < LANES; ln++) begin
      res[ln] = rnd();
      foreach (inflight[i])
        if (inflight[i].lane == ln && inflight[i].ti + inflight[i].lat == cyc) res[ln] = inflight[i].data;
    end

    bus.iss_valid = iv;
    bus.iss_wr    = iw;
    for (int ln = 0; ln < LANES; ln++) begin
      bus.iss_addr[ln*ADDR_W +: ADDR_W] = ADDR_W'(ia[ln]);
      bus.iss_lat[ln*LAT_W +: LAT_W]    = LAT_W'(il[ln]);
      bus.res_data[ln*DATA_W +: DATA_W] = res[ln];
    end
    for (int p = 0; p < NRD; p++) begin
      bus.rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(ra[p]);
      bus.rf_data[p*DATA_W +: DATA_W] = rf[p];
    end

    for (int p = 0; p < NRD; p++) begin
      int best = -1;
      bit rdy;
      foreach (inflight[i]) begin
        if (inflight[i].wr && inflight[i].addr == ra[p]) begin
          if (best < 0 || inflight[i].ti > inflight[best].ti ||
              (inflight[i].ti == inflight[best].ti && inflight[i].lane > inflight[best].lane))
            best = i;
        end
      end
      if (best < 0) begin
        m_hit[p]  = 1'b0;
        m_data[p] = rf[p];
      end else begin
`ifdef FWD_BYPASS_EN
        rdy = cyc >= inflight[best].ti + inflight[best].lat;
`else
        rdy = cyc > inflight[best].ti + inflight[best].lat;
`endif
        m_hit[p]  = rdy;
        m_data[p] = rdy ? inflight[best].data : rf[p];
        if (!rdy) hazard = 1'b1;
      end
    end

    for (int ln = 0; ln < LANES; ln++)
      if (iv[ln])
        foreach (inflight[i])
          if (inflight[i].lane == ln && inflight[i].ti + inflight[i].lat == cyc + eff_lat(il[ln]))
            conflict = 1'b1;
    m_stall = hazard | conflict;

    #3;
    if (!rst) begin
      check("iss_stall", bus.iss_stall, m_stall);
      check("lat_err", bus.lat_err, exp_lat_err);
      for (int p = 0; p < NRD; p++) begin
        check("rd_hit", bus.rd_hit[p], m_hit[p]);
        check("rd_data", bus.rd_data[p*DATA_W +: DATA_W], m_data[p]);
      end
    end

    exp_lat_err_nxt = 1'b0;
    if (!rst && !m_stall) begin
      for (int ln = 0; ln < LANES; ln++) begin
        if (iv[ln]) begin
          it.ti   = cyc;
          it.lane = ln;
          it.wr   = iw[ln];
          it.addr = ia[ln];
          it.lat  = eff_lat(il[ln]);
          it.data = id[ln];
          inflight.push_back(it);
          if (il[ln] == 0 || il[ln] >= DEPTH) exp_lat_err_nxt = 1'b1;
          if (iw[ln]) begin
            w.cyc  = cyc + DEPTH;
            w.addr = ia[ln];
            w.data = id[ln];
            wbq[ln].push_back(w);
          end
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    cyc++;
    exp_lat_err = exp_lat_err_nxt;
    #1;
  endtask

  task automatic step();
    eval();
    advance();
  endtask

  task automatic idle(int n);
    iv = '0;
    repeat (n) step();
  endtask

  task automatic apply_reset(int n);
    rst = 1'b1;
    iv  = '0;
    repeat (n) step();
    inflight.delete();
    for (int ln = 0; ln < LANES; ln++) wbq[ln].delete();
    exp_lat_err = 1'b0;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    bit due;
    if (!rst) begin
      for (int ln = 0; ln < LANES; ln++) begin
        due = wbq[ln].size() > 0 && wbq[ln][0].cyc == cyc;
        check("wb_en", bus.wb_en[ln], due);
        if (due) begin
          check("wb_addr", bus.wb_addr[ln*ADDR_W +: ADDR_W], wbq[ln][0].addr);
          check("wb_data", bus.wb_data[ln*DATA_W +: DATA_W], wbq[ln][0].data);
          void'(wbq[ln].pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    iv = '0;
    iw = '0;
    for (int ln = 0; ln < LANES; ln++) begin
      ia[ln] = 0;
      il[ln] = 1;
      id[ln] = '0;
    end
    for (int p = 0; p < NRD; p++) begin
      ra[p] = 127;
      rf[p] = rnd();
    end

    apply_reset(2);
    check("rst_wb_en", bus.wb_en, '0);
    check("rst_wb_addr", bus.wb_addr, '0);
    check("rst_wb_data", bus.wb_data, '0);
    check("rst_lat_err", bus.lat_err, 1'b0);
    check("rst_rd_hit", bus.rd_hit, '0);
    check("rst_rd_data", bus.rd_data[DATA_W-1:0], rf[0]);

    // Single producer: lane 0, addr 5, lat 2, data 0xA5.
    iv = 2'b01; iw = 2'b01; ia[0] = 5; il[0] = 2; id[0] = 128'hA5;
    eval();
    check("d1_accept", bus.iss_stall, 1'b0);
    advance();
    iv = '0; ra[0] = 5;
    eval();
    check("d1_t1_stall", bus.iss_stall, 1'b1);
    check("d1_t1_hit", bus.rd_hit[0], 1'b0);
    advance();
    eval();
`ifdef FWD_BYPASS_EN
    check("d1_t2_byp_hit", bus.rd_hit[0], 1'b1);
    check("d1_t2_byp_data", bus.rd_data[DATA_W-1:0], 128'hA5);
`else
    check("d1_t2_stall", bus.iss_stall, 1'b1);
`endif
    advance();
    eval();
    check("d1_t3_hit", bus.rd_hit[0], 1'b1);
    check("d1_t3_data", bus.rd_data[DATA_W-1:0], 128'hA5);
    advance();
    ra[0] = 127;
    idle(3);
    eval();
    check("d1_wb_en", bus.wb_en[0], 1'b1);
    check("d1_wb_addr", bus.wb_addr[ADDR_W-1:0], 5);
    advance();

    // Write-back slot conflict on lane 0: lat 6 then lat 5 collide, lat 6 then lat 4 do not.
    idle(2);
    iv = 2'b01; iw = 2'b01; ia[0] = 20; il[0] = 6; id[0] = rnd();
    step();
    il[0] = 5; id[0] = rnd();
    eval();
    check("d2_conflict", bus.iss_stall, 1'b1);
    advance();
    idle(DEPTH + 1);
    iv = 2'b01; il[0] = 6; id[0] = rnd();
    step();
    il[0] = 4; id[0] = rnd();
    eval();
    check("d2_no_conflict", bus.iss_stall, 1'b0);
    advance();

    // Both lanes write addr 9 in one group: lane 1 is the younger producer.
    idle(DEPTH + 1);
    iv = 2'b11; iw = 2'b11; ia[0] = 9; ia[1] = 9; il[0] = 1; il[1] = 1;
    id[0] = 128'h1; id[1] = 128'h2;
    step();
    iv = '0;
    step();
    ra[0] = 9;
    eval();
    check("d3_hit", bus.rd_hit[0], 1'b1);
    check("d3_youngest", bus.rd_data[DATA_W-1:0], 128'h2);
    advance();
    ra[0] = 127;

    // Illegal latency 0 is folded to DEPTH-1 and flagged for exactly one cycle.
    idle(DEPTH + 1);
    iv = 2'b01; iw = 2'b01; ia[0] = 11; il[0] = 0; id[0] = 128'h11;
    step();
    iv = '0;
    eval();
    check("d4_lat_err_on", bus.lat_err, 1'b1);
    advance();
    eval();
    check("d4_lat_err_off", bus.lat_err, 1'b0);
    advance();
    idle(DEPTH);

    // Reset with four entries in flight: no write-back afterwards, reads fall back to the RF.
    iv = 2'b11; iw = 2'b11; ia[0] = 12; ia[1] = 12; il[0] = 3; il[1] = 3;
    id[0] = rnd(); id[1] = rnd();
    step();
    id[0] = rnd(); id[1] = rnd();
    step();
    idle(1);
    apply_reset(1);
    ra[0] = 12;
    eval();
    check("d5_rd_hit", bus.rd_hit[0], 1'b0);
    check("d5_rd_data", bus.rd_data[DATA_W-1:0], rf[0]);
    check("d5_wb_en", bus.wb_en, '0);
    advance();
    idle(DEPTH + 1);
    ra[0] = 127;

    // Randomized traffic with occasional mid-stream resets.
    for (int n = 0; n < 600; n++) begin
      iv = LANES'($urandom);
      iw = LANES'($urandom);
      for (int ln = 0; ln < LANES; ln++) begin
        ia[ln] = $urandom_range(0, 15);
        il[ln] = ($urandom_range(0, 7) == 0) ? 7 * $urandom_range(0, 1) : $urandom_range(1, DEPTH - 1);
        id[ln] = rnd();
      end
      for (int p = 0; p < NRD; p++) begin
        ra[p] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 100 + p;
        rf[p] = rnd();
      end
      if ($urandom_range(0, 199) == 0) apply_reset(1);
      else step();
    end

    for (int p = 0; p < NRD; p++) ra[p] = 127;
    idle(DEPTH + 2);
    for (int ln = 0; ln < LANES; ln++) check("wb_drain", wbq[ln].size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/fwd_result_pipe.md
# fwd_result_pipe

Parametrised result pipeline and forwarding network for the SPU execute stage, generalising the fixed 2-lane, 7-stage packed-result chain into LANES issue lanes, DEPTH stages and NRD read ports. Issued instructions are tracked in flight and capture their functional-unit result at their latency stage. The block forwards the youngest matching result to read ports, detects RAW and write-back-slot hazards for issue stall, and presents retiring results as register-file write ports. It sits between the register file / operand fetch and the FU pipes.

## Interface

- LANES, 2, issue lanes; lane 0 is older than lane 1 and so on within one issue group
- DEPTH, 7, pipeline stages, numbered 1..DEPTH
- DATA_W, 128, result width
- ADDR_W, 7, register address width
- NRD, 6, forwarding read ports
- LAT_W, $clog2(DEPTH+1), latency field width

- clk  in  1  clock
- rst  in  1  reset; synchronous and active-high
- iss_valid  in  LANES  instruction issued on lane
- iss_wr  in  LANES  instruction writes a register
- iss_addr  in  LANES*ADDR_W  destination register
- iss_lat  in  LANES*LAT_W  result latency in cycles, legal 1..DEPTH-1
- iss_stall  out  1  issue group rejected this cycle; upstream holds
- res_data  in  LANES*DATA_W  FU result for the lane entry currently at its latency stage
- rd_addr  in  NRD*ADDR_W  operand register address
- rf_data  in  NRD*DATA_W  register-file read data for the same port
- rd_data  out  NRD*DATA_W  forwarded or RF operand
- rd_hit  out  NRD  operand supplied from the pipeline
- wb_en  out  LANES  write-back enable (stage DEPTH)
- wb_addr  out  LANES*ADDR_W  write-back address
- wb_data  out  LANES*DATA_W  write-back data
- lat_err  out  1  registered pulse: an accepted issue carried an illegal latency

## Operation

- Entry per lane per stage: valid, wr, addr, lat, rdy, data. All stages shift by one every cycle, unconditionally. Stage DEPTH drops out after driving wb_*.
- Accept: if iss_stall=0, each iss_valid lane loads stage 1 with rdy=0. Otherwise stage 1 loads a bubble on every lane, so the whole group is held together.
- Illegal iss_lat (0 or ≥DEPTH) is replaced by DEPTH-1 and raises lat_err for one cycle.
- Capture: an entry sitting at stage s==lat latches res_data of its lane and sets rdy=1 as it moves to s+1.
- Slot conflict, per lane:
  - Issue lat L conflicts with an in-flight valid entry at stage a with lat La when L == La-a and La > a.
  - Two results on one lane in one cycle are therefore impossible.
- Read lookup, per port:
  - Candidates: valid, wr entries with addr==rd_addr.
  - Youngest wins: lowest stage first; within a stage, highest lane first.
  - Winner rdy=1: rd_data=winner data, rd_hit=1.
  - Winner rdy=0: rd_data=rf_data, rd_hit=0, RAW hazard.
  - No candidate: rd_data=rf_data, rd_hit=0.
- iss_stall = (any lane slot conflict for a valid issuing lane) OR (any RAW hazard on an enabled port). All NRD ports are treated as enabled.
- Intra-group dependences are not checked here; the issue logic owns them.
- wb_en = valid & wr at stage DEPTH.

## Timing

- Reset: all entries invalid. wb_en=0, lat_err=0, wb_addr=0, wb_data=0; rd_hit=0 and rd_data=rf_data (combinational).
- Issue at cycle t: the entry is in stage 1 at t+1 and at stage L at t+L (the capture edge). It is forwardable from t+L+1 and on wb_* during t+DEPTH.
- rd_*, iss_stall: combinational from the current entries and inputs. wb_*: direct from stage DEPTH registers. lat_err: registered.
- A write-back in cycle t is also forwarded in cycle t, because the RF updates at the end of t.
- Reset mid-operation discards all in-flight entries with no write-back.

## Configuration

- FWD_BYPASS_EN defined: an entry at stage s==lat counts as ready for lookup, with rd_data=res_data of its lane that cycle. The dependent operand is available at t+L.
- FWD_BYPASS_EN undefined: such an entry is a RAW hazard. Its data is available from t+L+1 only.

## Test plan

- Issue lane0 addr 5, lat 2, data 0xA5 supplied at t+2; read addr 5 at t+3 -> rd_hit=1, rd_data=0xA5; wb_en[0]=1, wb_addr=5 at t+7.
- Same issue, read addr 5 at t+1 -> iss_stall=1, rd_hit=0. At t+2: iss_stall=1 without bypass; with FWD_BYPASS_EN, rd_hit=1 and data=res_data.
- Lane0 lat 6 at t, then lane0 lat 5 at t+1 -> iss_stall=1 at t+1. The same pair with lat 4 is accepted.
- Lane0 and lane1 both write addr 9 at t, data 0x1/0x2, lat 1; read addr 9 at t+2 -> rd_data=0x2 (lane1 younger).
- Issue with iss_lat=0 -> lat_err=1 for one cycle; result captured at stage 6.
- rst at t+3 with four entries in flight -> wb_en=0 from t+4 through t+DEPTH+4; a read of the same address returns rf_data.
